// File: rtl/upscaler_pkg.sv
// Shared defaults, bank index type and scheduler state encoding for the line upscaler.
// No logic and no timing: declarations only.
package upscaler_pkg;

    localparam int NUM_BANKS_DEF   = 4;
    localparam int SRC_LINES_DEF   = 240;
    localparam int OUT_LINES_DEF   = 720;
    localparam int PRIME_LINES_DEF = 2;

    localparam int BANK_W = $clog2(NUM_BANKS_DEF);

    typedef logic [BANK_W-1:0] bank_idx_t;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_PRIME   = 2'd1,
        S_RUN     = 2'd2
    } sched_state_t;

endpackage

// File: rtl/line_bank_scheduler_if.sv
// Capture/display pulses in, bank pointers and status out; master drives pulses.
// Pure wiring, no latency; no backpressure, every pulse is consumed the cycle it arrives.
interface line_bank_scheduler_if import upscaler_pkg::*; #(
    parameter int NUM_BANKS = NUM_BANKS_DEF
) ();
    localparam int BW = $clog2(NUM_BANKS);

    logic          src_line_done;
    logic          src_vsync;
    logic          out_line_start;
    logic          out_frame_start;
    logic          out_line_active;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic          rd_valid;
    logic [BW:0]   fill;
    logic [15:0]   overrun_cnt;
    logic [15:0]   underrun_cnt;

    modport master (
        output src_line_done, src_vsync, out_line_start, out_frame_start, out_line_active,
        input  wr_bank, rd_bank, rd_valid, fill, overrun_cnt, underrun_cnt
    );

    modport slave (
        input  src_line_done, src_vsync, out_line_start, out_frame_start, out_line_active,
        output wr_bank, rd_bank, rd_valid, fill, overrun_cnt, underrun_cnt
    );

endinterface

// File: rtl/line_step_accum.sv
// Fractional SRC/OUT line stepper: raises advance when the accumulated source position crosses a line.
// Advance is combinational from the registered accumulator (state updates next edge); no backpressure.
module line_step_accum import upscaler_pkg::*; #(
    parameter int SRC_LINES = SRC_LINES_DEF,
    parameter int OUT_LINES = OUT_LINES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic clear,
    output logic advance
);
    localparam int AW  = $clog2(OUT_LINES) + 1;
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] SRC_W = AW1'(SRC_LINES);
    localparam logic [AW:0] OUT_W = AW1'(OUT_LINES);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW:0]   base;
    logic [AW:0]   sum;

    // A frame start zeroes the position before the same line's step is added.
    always_comb begin
        base    = clear ? '0 : {1'b0, acc_q};
        sum     = base + SRC_W;
        advance = 1'b0;
        acc_d   = base[AW-1:0];
        if (step) begin
            if (sum >= OUT_W) begin
                advance = 1'b1;
                acc_d   = AW'(sum - OUT_W);
            end else begin
                acc_d   = sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/line_bank_scheduler.sv
// Line-buffer ring scheduler: picks capture/display banks, tracks fill, counts overruns/underruns.
// All outputs registered, latency 1 cycle from the triggering pulse; no backpressure, overflow overwrites.
module line_bank_scheduler import upscaler_pkg::*; #(
    parameter int NUM_BANKS   = NUM_BANKS_DEF,
    parameter int SRC_LINES   = SRC_LINES_DEF,
    parameter int OUT_LINES   = OUT_LINES_DEF,
    parameter int PRIME_LINES = PRIME_LINES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    line_bank_scheduler_if.slave    bus
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int FW = BW + 1;
    localparam logic [FW-1:0] FULL_LVL  = FW'(NUM_BANKS - 1);
    localparam logic [FW-1:0] PRIME_LVL = FW'(PRIME_LINES);
    localparam logic [FW-1:0] ONE_F     = FW'(1);
    localparam logic [BW-1:0] ONE_B     = BW'(1);

    sched_state_t  state_q, state_d;
    logic [BW-1:0] wr_q, wr_d;
    logic [BW-1:0] rd_q, rd_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          valid_q;
    logic [15:0]   ovr_q, ovr_d;
    logic [15:0]   und_q, und_d;

    logic step;
    logic adv;
    logic take_adv;
    logic take_line;
    logic lost_line;

    assign step = (state_q == S_RUN) && bus.out_line_start && bus.out_line_active;

    line_step_accum #(
        .SRC_LINES (SRC_LINES),
        .OUT_LINES (OUT_LINES)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .clear   (bus.out_frame_start),
        .advance (adv)
    );

    // An advance frees the displayed bank in the same cycle, so a line arriving
    // with it is accepted even at full; wr_bank then stays NUM_BANKS-1 ahead of rd_bank.
    always_comb begin
        take_adv  = adv && (fill_q > ONE_F);
        take_line = bus.src_line_done && (state_q != S_WAIT_VS) && !bus.src_vsync
                    && ((fill_q < FULL_LVL) || take_adv);
        lost_line = bus.src_line_done && (state_q != S_WAIT_VS) && !bus.src_vsync && !take_line;
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        ovr_d   = ovr_q;
        und_d   = und_q;

        if (take_line) begin
            wr_d = wr_q + ONE_B;
        end
        if (lost_line && ovr_q != 16'hFFFF) begin
            ovr_d = ovr_q + 16'd1;
        end
        if (take_adv) begin
            rd_d = rd_q + ONE_B;
        end
        if (adv && !take_adv && und_q != 16'hFFFF) begin
            und_d = und_q + 16'd1;
        end
        if (take_line && !take_adv) begin
            fill_d = fill_q + ONE_F;
        end else if (take_adv && !take_line) begin
            fill_d = fill_q - ONE_F;
        end

        case (state_q)
            S_WAIT_VS: begin
                if (bus.src_vsync) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                // A new field restarts priming from the bank capture is about to write.
                if (bus.src_vsync) begin
                    fill_d = '0;
                    rd_d   = wr_q;
                end else if (fill_d == PRIME_LVL) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_WAIT_VS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_WAIT_VS;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
            und_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            valid_q <= (state_d == S_RUN);
            ovr_q   <= ovr_d;
            und_q   <= und_d;
        end
    end

    assign bus.wr_bank      = wr_q;
    assign bus.rd_bank      = rd_q;
    assign bus.rd_valid     = valid_q;
    assign bus.fill         = fill_q;
    assign bus.overrun_cnt  = ovr_q;
    assign bus.underrun_cnt = und_q;

endmodule
